// File: rtl/frame_buffer_writer.sv
// Write port for the 160x120 1-bit VGA frame buffer: single-pixel writes, full-screen fills
// that can wait for vertical sync, and the colour register read by the VGA generator.
module frame_buffer_writer #(
  parameter int          H_PIXELS        = 160,
  parameter int          V_PIXELS        = 120,
  parameter logic [15:0] DEFAULT_COLOURS = 16'hFF00,
  parameter bit          FILL_ON_VSYNC   = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_OP,
  input  logic [7:0]  CMD_X,
  input  logic [6:0]  CMD_Y,
  input  logic [15:0] CMD_DATA,
  input  logic        VGA_VS,
  output logic [14:0] BUF_ADDR,
  output logic        BUF_DATA,
  output logic        BUF_WE,
  output logic [15:0] CONFIG_COLOURS,
  output logic        BUSY,
  output logic        ERR
);
  localparam logic [7:0] X_LAST     = 8'(H_PIXELS - 1);
  localparam logic [6:0] Y_LAST     = 7'(V_PIXELS - 1);
  localparam logic [1:0] OP_WRITE   = 2'b00;
  localparam logic [1:0] OP_FILL    = 2'b01;
  localparam logic [1:0] OP_COLOURS = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT_VS, FILL} state_t;

  state_t      state_q, state_d;
  logic [14:0] buf_addr_q, buf_addr_d;
  logic        buf_data_q, buf_data_d;
  logic        buf_we_q, buf_we_d;
  logic [15:0] colours_q, colours_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        vs_q;
  logic [7:0]  fx_q, fx_d;
  logic [6:0]  fy_q, fy_d;
  logic        fill_val_q, fill_val_d;

  logic cmd_fire;
  logic vs_fall;

  assign CMD_READY      = (state_q == IDLE);
  assign cmd_fire       = CMD_VALID & CMD_READY;
  // vs_q only tracks the pin, so a sync already low when WAIT_VS is entered never looks like a fall
  assign vs_fall        = vs_q & ~VGA_VS;

  assign BUF_ADDR       = buf_addr_q;
  assign BUF_DATA       = buf_data_q;
  assign BUF_WE         = buf_we_q;
  assign CONFIG_COLOURS = colours_q;
  assign BUSY           = busy_q;
  assign ERR            = err_q;

  always_comb begin
    state_d    = state_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    buf_we_d   = 1'b0;
    colours_d  = colours_q;
    err_d      = 1'b0;
    fx_d       = fx_q;
    fy_d       = fy_q;
    fill_val_d = fill_val_q;

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          case (CMD_OP)
            OP_WRITE: begin
              if (CMD_X <= X_LAST && CMD_Y <= Y_LAST) begin
                buf_we_d   = 1'b1;
                buf_addr_d = {CMD_Y, CMD_X};
                buf_data_d = CMD_DATA[0];
              end else begin
                err_d = 1'b1;
              end
            end
            OP_FILL: begin
              fill_val_d = CMD_DATA[0];
              fx_d       = '0;
              fy_d       = '0;
              state_d    = FILL_ON_VSYNC ? WAIT_VS : FILL;
            end
            OP_COLOURS: colours_d = CMD_DATA;
            default:    err_d = 1'b1;
          endcase
        end
      end
      WAIT_VS: begin
        if (vs_fall) state_d = FILL;
      end
      FILL: begin
        buf_we_d   = 1'b1;
        buf_addr_d = {fy_q, fx_q};
        buf_data_d = fill_val_q;
        if (fx_q == X_LAST) begin
          fx_d = '0;
          if (fy_q == Y_LAST) state_d = IDLE;
          else                fy_d = fy_q + 7'd1;
        end else begin
          fx_d = fx_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      buf_addr_q <= '0;
      buf_data_q <= 1'b0;
      buf_we_q   <= 1'b0;
      colours_q  <= DEFAULT_COLOURS;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      vs_q       <= 1'b1;
      fx_q       <= '0;
      fy_q       <= '0;
      fill_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      buf_we_q   <= buf_we_d;
      colours_q  <= colours_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      vs_q       <= VGA_VS;
      fx_q       <= fx_d;
      fy_q       <= fy_d;
      fill_val_q <= fill_val_d;
    end
  end
endmodule

// File: tb/tb_frame_buffer_writer.sv
// Bench for frame_buffer_writer: command table plus hand sequences for vsync-gated fill and
// reset during a fill; RAM-port events are checked against a scoreboard queue.
module tb_frame_buffer_writer;
  logic        CLK;
  logic        RESET;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [1:0]  CMD_OP;
  logic [7:0]  CMD_X;
  logic [6:0]  CMD_Y;
  logic [15:0] CMD_DATA;
  logic        VGA_VS;
  logic [14:0] BUF_ADDR;
  logic        BUF_DATA;
  logic        BUF_WE;
  logic [15:0] CONFIG_COLOURS;
  logic        BUSY;
  logic        ERR;

  frame_buffer_writer dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .CMD_VALID      (CMD_VALID),
    .CMD_READY      (CMD_READY),
    .CMD_OP         (CMD_OP),
    .CMD_X          (CMD_X),
    .CMD_Y          (CMD_Y),
    .CMD_DATA       (CMD_DATA),
    .VGA_VS         (VGA_VS),
    .BUF_ADDR       (BUF_ADDR),
    .BUF_DATA       (BUF_DATA),
    .BUF_WE         (BUF_WE),
    .CONFIG_COLOURS (CONFIG_COLOURS),
    .BUSY           (BUSY),
    .ERR            (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // kind: 0 = RAM write, 1 = ERR pulse, 2 = no port event
  typedef struct {
    logic [1:0]  kind;
    logic [14:0] addr;
    logic        data;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [15:0] data;
    logic [1:0]  kind;
    logic [14:0] addr;
    logic        wdata;
    logic [15:0] colours;
    int          gap;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  int   total = 0;
  int   bad = 0;
  int   we_count = 0;
  logic [1:0] mon_kind;
  exp_t mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every WE or ERR cycle must match the next queued expectation.
  always @(negedge CLK) begin
    if (!RESET && (BUF_WE || ERR)) begin
      if (BUF_WE) we_count++;
      mon_kind = (BUF_WE && !ERR) ? 2'd0 : ((ERR && !BUF_WE) ? 2'd1 : 2'd3);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got kind=%0d addr=0x%0h, required no event", mon_kind, BUF_ADDR);
      end else begin
        mon_exp = sb.pop_front();
        check("event_kind", 32'(mon_kind), 32'(mon_exp.kind));
        if (mon_exp.kind == 2'd0) begin
          check("write_addr", 32'(BUF_ADDR), 32'(mon_exp.addr));
          check("write_data", 32'(BUF_DATA), 32'(mon_exp.data));
        end
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] x, input logic [6:0] y,
                          input logic [15:0] d);
    int n = 0;
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_X     = x;
    CMD_Y     = y;
    CMD_DATA  = d;
    while (!CMD_READY && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!CMD_READY) begin
      total++;
      bad++;
      $display("FAIL cmd_accept_timeout: ready=0 after %0d cycles, required 1", n);
    end
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic push_fill(input logic val);
    exp_t e;
    for (int fy = 0; fy < 120; fy++) begin
      for (int fx = 0; fx < 160; fx++) begin
        e.kind = 2'd0;
        e.addr = {7'(fy), 8'(fx)};
        e.data = val;
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    exp_t e;
    int   n;
    int   run;
    int   bad_cycles;
    int   base;
    logic [14:0] first_addr;
    logic [14:0] last_addr;

    vecs[0] = '{2'd0, 8'd10,  7'd5,   16'h0001, 2'd0, 15'h050A, 1'b1, 16'hFF00, 2};
    vecs[1] = '{2'd0, 8'd0,   7'd0,   16'h0000, 2'd0, 15'h0000, 1'b0, 16'hFF00, 0};
    vecs[2] = '{2'd0, 8'd159, 7'd119, 16'h0001, 2'd0, 15'h779F, 1'b1, 16'hFF00, 0};
    vecs[3] = '{2'd0, 8'd1,   7'd1,   16'h0001, 2'd0, 15'h0101, 1'b1, 16'hFF00, 2};
    vecs[4] = '{2'd0, 8'd160, 7'd0,   16'h0001, 2'd1, 15'h0000, 1'b0, 16'hFF00, 1};
    vecs[5] = '{2'd0, 8'd0,   7'd120, 16'h0001, 2'd1, 15'h0000, 1'b0, 16'hFF00, 1};
    vecs[6] = '{2'd3, 8'd0,   7'd0,   16'h0000, 2'd1, 15'h0000, 1'b0, 16'hFF00, 1};
    vecs[7] = '{2'd2, 8'd0,   7'd0,   16'h1CE3, 2'd2, 15'h0000, 1'b0, 16'h1CE3, 1};
    vecs[8] = '{2'd0, 8'd255, 7'd127, 16'h0001, 2'd1, 15'h0000, 1'b0, 16'h1CE3, 0};
    vecs[9] = '{2'd0, 8'd159, 7'd0,   16'h0000, 2'd0, 15'h009F, 1'b0, 16'h1CE3, 2};

    RESET = 1'b1; CMD_VALID = 1'b0; CMD_OP = 2'd0; CMD_X = 8'd0; CMD_Y = 7'd0;
    CMD_DATA = 16'd0; VGA_VS = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_addr",    32'(BUF_ADDR), 32'h0);
    check("rst_data",    32'(BUF_DATA), 32'h0);
    check("rst_we",      32'(BUF_WE), 32'h0);
    check("rst_busy",    32'(BUSY), 32'h0);
    check("rst_err",     32'(ERR), 32'h0);
    check("rst_colours", 32'(CONFIG_COLOURS), 32'hFF00);
    check("rst_ready",   32'(CMD_READY), 32'h1);
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Command table: single write, back-to-back writes, rejects, colours.
    for (int i = 0; i < 10; i++) begin
      $display("cmd %0d: op=%0d x=%0d y=%0d data=0x%04h", i, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].data);
      if (vecs[i].kind != 2'd2) begin
        e.kind = vecs[i].kind;
        e.addr = vecs[i].addr;
        e.data = vecs[i].wdata;
        sb.push_back(e);
      end
      check("ready_idle", 32'(CMD_READY), 32'h1);
      send_cmd(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].data);
      check("colours", 32'(CONFIG_COLOURS), 32'(vecs[i].colours));
      repeat (vecs[i].gap) begin
        @(posedge CLK); #1;
      end
    end
    repeat (3) @(posedge CLK);
    #1;
    check("table_drained", 32'(sb.size()), 32'h0);

    // Fill gated by a vsync fall.
    $display("fill: value=1, vsync held high for 50 cycles");
    push_fill(1'b1);
    send_cmd(2'd1, 8'd0, 7'd0, 16'h0001);
    bad_cycles = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge CLK);
      if (BUSY !== 1'b1 || BUF_WE !== 1'b0 || CMD_READY !== 1'b0) bad_cycles++;
    end
    check("wait_vs_bad_cycles", 32'(bad_cycles), 32'h0);
    @(posedge CLK); #1;
    VGA_VS = 1'b0;
    @(negedge CLK);
    n = 0;
    while (!BUF_WE && n < 10) begin
      @(negedge CLK);
      n++;
    end
    check("fill_start", 32'(BUF_WE), 32'h1);
    first_addr = BUF_ADDR;
    last_addr  = BUF_ADDR;
    run = 0;
    while (BUF_WE && run < 20000) begin
      last_addr = BUF_ADDR;
      run++;
      @(negedge CLK);
    end
    check("fill_run_length", 32'(run), 32'd19200);
    check("fill_first_addr", 32'(first_addr), 32'h0000);
    check("fill_last_addr",  32'(last_addr), 32'h779F);
    check("fill_done_ready", 32'(CMD_READY), 32'h1);
    check("fill_done_busy",  32'(BUSY), 32'h0);
    check("fill_drained",    32'(sb.size()), 32'h0);

    // Fill entered with vsync already low, then reset after 1000 writes.
    $display("fill: value=0, vsync low on entry, reset after 1000 writes");
    push_fill(1'b0);
    send_cmd(2'd1, 8'd0, 7'd0, 16'h0000);
    bad_cycles = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (BUSY !== 1'b1 || BUF_WE !== 1'b0) bad_cycles++;
    end
    check("vs_low_on_entry_bad_cycles", 32'(bad_cycles), 32'h0);
    @(posedge CLK); #1;
    VGA_VS = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    VGA_VS = 1'b0;
    base = we_count;
    n = 0;
    while ((we_count - base) < 1000 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check("fill_writes_before_reset", 32'(we_count - base), 32'd1000);
    #1;
    RESET = 1'b1;
    sb.delete();
    #1;
    check("midfill_rst_we",      32'(BUF_WE), 32'h0);
    check("midfill_rst_busy",    32'(BUSY), 32'h0);
    check("midfill_rst_addr",    32'(BUF_ADDR), 32'h0);
    check("midfill_rst_colours", 32'(CONFIG_COLOURS), 32'hFF00);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    check("post_rst_ready", 32'(CMD_READY), 32'h1);
    check("post_rst_busy",  32'(BUSY), 32'h0);
    $display("cmd after reset: op=0 x=3 y=2 data=0x0001");
    e.kind = 2'd0;
    e.addr = 15'h0203;
    e.data = 1'b1;
    sb.push_back(e);
    send_cmd(2'd0, 8'd3, 7'd2, 16'h0001);
    repeat (5) @(posedge CLK);
    #1;
    check("post_rst_drained", 32'(sb.size()), 32'h0);
    check("post_rst_no_busy", 32'(BUSY), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
